// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the iterative NxN multiplier slice:
//   state_t     - sequencer states (IDLE, RUN, FIX)
//   DEF_WIDTH   - default operand width in bits
//   DEF_CHUNK   - default partial-product slice width in bits
// -----------------------------------------------------------------------------
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 16;

endpackage

// File: rtl/multnxn_iter_fsm.sv
// -----------------------------------------------------------------------------
// multnxn_iter_fsm
// Sequencer for the iterative multiplier. Walks the K x K slice grid with
// j outer / i inner, then spends one cycle in FIX before returning to IDLE.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             new-operation request (honoured only in IDLE)
//   o_busy              registered, high in RUN and FIX
//   o_done              registered, one-cycle pulse on the first IDLE cycle
//   o_clr               latch operands / clear accumulator (IDLE and start)
//   o_upd               accumulate the current partial product (RUN)
//   o_neg               apply the sign correction (FIX)
//   o_si, o_sj          current a-slice / b-slice indices
// -----------------------------------------------------------------------------
module multnxn_iter_fsm
   import mult_pkg::*;
#(
   parameter int K  = 2,
   parameter int SW = 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_clr,
   output logic          o_upd,
   output logic          o_neg,
   output logic [SW-1:0] o_si,
   output logic [SW-1:0] o_sj
);

   localparam logic [SW-1:0] LAST = SW'(K - 1);

   state_t        r_state;
   logic [SW-1:0] r_si;
   logic [SW-1:0] r_sj;
   logic          r_busy;
   logic          r_done;

   // State, slice counters, busy and done pulse
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_si    <= '0;
         r_sj    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state <= RUN;
                  r_si    <= '0;
                  r_sj    <= '0;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               // i is the inner index; wrap it and step j, leave after (K-1,K-1)
               if (r_si == LAST) begin
                  r_si <= '0;
                  if (r_sj == LAST) begin
                     r_sj    <= '0;
                     r_state <= FIX;
                  end else begin
                     r_sj <= r_sj + SW'(1);
                  end
               end else begin
                  r_si <= r_si + SW'(1);
               end
            end
            FIX: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Strobes are decoded straight from the state register so the datapath
   // acts on the same edge that moves the state
   assign o_clr  = (r_state == IDLE) && i_start;
   assign o_upd  = (r_state == RUN);
   assign o_neg  = (r_state == FIX);
   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_si   = r_si;
   assign o_sj   = r_sj;

endmodule

// File: rtl/multnxn_iter.sv
// -----------------------------------------------------------------------------
// multnxn_iter
// Iterative signed/unsigned WIDTH x WIDTH multiplier. Operands are reduced to
// magnitudes on start, one CHUNK x CHUNK partial product is accumulated per
// RUN cycle (K*K cycles, K = WIDTH/CHUNK), and FIX negates the result when
// the operand signs differ. WIDTH must be a multiple of CHUNK.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          request a multiplication (accepted only when idle)
//   i_is_signed      1 = two's-complement operands
//   i_a, i_b         operands, sampled with an accepted start
//   o_busy           high while an operation is in progress
//   o_done           one-cycle pulse when o_product becomes valid
//   o_product        2*WIDTH result, held until the next accepted start
// -----------------------------------------------------------------------------
module multnxn_iter
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_is_signed,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_busy,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_product
);

   localparam int K   = WIDTH / CHUNK;
   localparam int SW  = (K > 1) ? $clog2(K) : 1;
   localparam int PW  = 2 * WIDTH;
   localparam int PPW = 2 * CHUNK;

   // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1), which
   // still fits because the result is treated as unsigned
   function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                              input logic             sgn);
      if (sgn && v[WIDTH-1]) begin
         f_mag = (~v) + WIDTH'(1);
      end else begin
         f_mag = v;
      end
   endfunction

   logic             w_clr;
   logic             w_upd;
   logic             w_neg;
   logic [SW-1:0]    w_si;
   logic [SW-1:0]    w_sj;
   logic [31:0]      w_a_off;
   logic [31:0]      w_b_off;
   logic [31:0]      w_shift;
   logic [CHUNK-1:0] w_a_slice;
   logic [CHUNK-1:0] w_b_slice;
   logic [PPW-1:0]   w_pp;
   logic [PW-1:0]    w_term;

   logic [WIDTH-1:0] r_a_mag;
   logic [WIDTH-1:0] r_b_mag;
   logic             r_neg;
   logic [PW-1:0]    r_product;

   multnxn_iter_fsm #(
      .K  (K),
      .SW (SW)
   ) u_fsm (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_start (i_start),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_clr   (w_clr),
      .o_upd   (w_upd),
      .o_neg   (w_neg),
      .o_si    (w_si),
      .o_sj    (w_sj)
   );

   // Slice selection by shifting avoids variable part-selects
   assign w_a_off   = 32'(w_si) * 32'(CHUNK);
   assign w_b_off   = 32'(w_sj) * 32'(CHUNK);
   assign w_shift   = w_a_off + w_b_off;
   assign w_a_slice = CHUNK'(r_a_mag >> w_a_off);
   assign w_b_slice = CHUNK'(r_b_mag >> w_b_off);
   assign w_pp      = PPW'(w_a_slice) * PPW'(w_b_slice);
   assign w_term    = PW'(w_pp) << w_shift;

   // Operand latch, accumulation and final sign correction
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_a_mag   <= '0;
         r_b_mag   <= '0;
         r_neg     <= 1'b0;
         r_product <= '0;
      end else if (w_clr) begin
         r_a_mag   <= f_mag(i_a, i_is_signed);
         r_b_mag   <= f_mag(i_b, i_is_signed);
         r_neg     <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
         r_product <= '0;
      end else if (w_upd) begin
         r_product <= r_product + w_term;
      end else if (w_neg && r_neg) begin
         r_product <= PW'(0) - r_product;
      end
   end

   assign o_product = r_product;

endmodule

// File: tb/tb_multnxn_iter.sv
// -----------------------------------------------------------------------------
// tb_multnxn_iter
// Scoreboard bench for multnxn_iter: one 32/16 instance and one 8/4 instance.
// Stimulus pushes the reference product into a per-instance queue; monitors
// pop and compare on every done pulse and also check busy length.
// -----------------------------------------------------------------------------
module tb_multnxn_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // 32-bit instance
   logic        r32 = 1'b1, s32_start = 1'b0, s32_sgn = 1'b0;
   logic [31:0] s32_a = 32'd0, s32_b = 32'd0;
   logic        d32_busy, d32_done;
   logic [63:0] d32_prod;

   // 8-bit instance
   logic        r8 = 1'b1, s8_start = 1'b0, s8_sgn = 1'b0;
   logic [7:0]  s8_a = 8'd0, s8_b = 8'd0;
   logic        d8_busy, d8_done;
   logic [15:0] d8_prod;

   logic [63:0] q32[$];
   logic [15:0] q8[$];

   multnxn_iter #(.WIDTH(32), .CHUNK(16)) u_dut32 (
      .i_clk(clk), .i_reset(r32), .i_start(s32_start), .i_is_signed(s32_sgn),
      .i_a(s32_a), .i_b(s32_b), .o_busy(d32_busy), .o_done(d32_done),
      .o_product(d32_prod));

   multnxn_iter #(.WIDTH(8), .CHUNK(4)) u_dut8 (
      .i_clk(clk), .i_reset(r8), .i_start(s8_start), .i_is_signed(s8_sgn),
      .i_a(s8_a), .i_b(s8_b), .o_busy(d8_busy), .o_done(d8_done),
      .o_product(d8_prod));

   // Reference model: plain arithmetic multiply in the requested mode
   function automatic logic [63:0] ref32(input logic s, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   function automatic logic [15:0] ref8(input logic s, input logic [7:0] a,
                                        input logic [7:0] b);
      int sa, sb;
      if (s) begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         return 16'(sa * sb);
      end
      return {8'd0, a} * {8'd0, b};
   endfunction

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitors: compare product on done, check busy length and done width
   int  bc32 = 0, bc8 = 0;
   logic pd32 = 1'b0, pd8 = 1'b0;
   logic [63:0] e32;
   logic [15:0] e8;

   always @(negedge clk) begin
      if (r32) begin
         bc32 = 0;
      end else if (d32_done) begin
         check("done32_single", 64'(pd32), 64'd0);
         check("busy32_len", 64'(bc32), 64'd5);
         bc32 = 0;
         n_tests++;
         if (q32.size() == 0) begin
            n_fail++;
            $display("FAIL prod32: unexpected done, product %h", d32_prod);
         end else begin
            e32 = q32.pop_front();
            if (d32_prod !== e32) begin
               n_fail++;
               $display("FAIL prod32: got %h expected %h", d32_prod, e32);
            end
         end
      end else if (d32_busy) begin
         bc32++;
      end
      pd32 = d32_done;
   end

   always @(negedge clk) begin
      if (r8) begin
         bc8 = 0;
      end else if (d8_done) begin
         check("done8_single", 64'(pd8), 64'd0);
         check("busy8_len", 64'(bc8), 64'd5);
         bc8 = 0;
         n_tests++;
         if (q8.size() == 0) begin
            n_fail++;
            $display("FAIL prod8: unexpected done, product %h", d8_prod);
         end else begin
            e8 = q8.pop_front();
            if (d8_prod !== e8) begin
               n_fail++;
               $display("FAIL prod8: got %h expected %h", d8_prod, e8);
            end
         end
      end else if (d8_busy) begin
         bc8++;
      end
      pd8 = d8_done;
   end

   // Issue one start (DUT must be idle); operands scrambled afterwards
   task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic push, input logic [63:0] exp);
      if (push) q32.push_back(exp);
      s32_start = 1'b1; s32_sgn = s; s32_a = a; s32_b = b;
      @(posedge clk); #1;
      s32_start = 1'b0; s32_sgn = $urandom_range(0, 1); s32_a = $urandom; s32_b = $urandom;
   endtask

   task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
      q8.push_back(exp);
      s8_start = 1'b1; s8_sgn = s; s8_a = a; s8_b = b;
      @(posedge clk); #1;
      s8_start = 1'b0; s8_sgn = $urandom_range(0, 1); s8_a = 8'($urandom); s8_b = 8'($urandom);
   endtask

   task automatic wait_done32(input string name);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (d32_done) begin seen = 1'b1; break; end
      end
      check({name, "_timeout"}, 64'(seen), 64'd1);
   endtask

   task automatic wait_done8(input string name);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (d8_done) begin seen = 1'b1; break; end
      end
      check({name, "_timeout"}, 64'(seen), 64'd1);
   endtask

   logic [31:0] edge32 [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
   logic [31:0] ra, rb;
   logic [7:0]  ra8, rb8;
   logic        rs;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1; r32 = 1'b0; r8 = 1'b0;
      @(negedge clk);
      check("rst32_busy", 64'(d32_busy), 64'd0);
      check("rst32_done", 64'(d32_done), 64'd0);
      check("rst32_prod", d32_prod, 64'd0);
      check("rst8_busy", 64'(d8_busy), 64'd0);
      check("rst8_prod", 64'(d8_prod), 64'd0);

      // Directed 32-bit cases
      issue32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE00000001);
      wait_done32("umax");
      issue32(1'b1, 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFF1);
      wait_done32("m3x5");
      issue32(1'b1, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
      wait_done32("minmin");
      issue32(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1);
      wait_done32("m1m1");
      check("hold32", d32_prod, 64'h1);

      // Start during RUN is ignored
      issue32(1'b0, 32'd7, 32'd6, 1'b1, 64'd42);
      s32_start = 1'b1; s32_a = 32'd0; s32_b = 32'd0;
      @(posedge clk); #1;
      s32_start = 1'b0;
      wait_done32("ignore_start");
      repeat (8) @(negedge clk);

      // Reset on the third RUN cycle aborts with no done
      issue32(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 64'd0);
      @(posedge clk); @(posedge clk); #1;
      r32 = 1'b1;
      @(posedge clk); #1;
      r32 = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(d32_busy), 64'd0);
      check("abort_prod", d32_prod, 64'd0);
      repeat (8) @(negedge clk);
      issue32(1'b0, 32'd2, 32'd3, 1'b1, 64'd6);
      wait_done32("after_abort");

      // Back-to-back: start held high through the done cycle
      q32.push_back(64'd100);
      q32.push_back(64'd0);
      s32_start = 1'b1; s32_sgn = 1'b0; s32_a = 32'd10; s32_b = 32'd10;
      @(posedge clk); #1;
      s32_a = 32'd0; s32_b = 32'd5;
      wait_done32("b2b_first");
      @(posedge clk); #1;
      s32_start = 1'b0;
      check("b2b_restart_busy", 64'(d32_busy), 64'd1);
      wait_done32("b2b_second");

      // Random 32-bit ops with boundary operands mixed in
      for (int n = 0; n < 150; n++) begin
         rs = 1'($urandom_range(0, 1));
         ra = ($urandom_range(0, 3) == 0) ? edge32[$urandom_range(0, 4)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? edge32[$urandom_range(0, 4)] : $urandom;
         issue32(rs, ra, rb, 1'b1, ref32(rs, ra, rb));
         wait_done32("rand32");
      end

      // 8-bit instance: directed then random
      issue8(1'b1, 8'h80, 8'h7F, 16'hC080);
      wait_done8("s80x7f");
      for (int n = 0; n < 1000; n++) begin
         rs  = 1'($urandom_range(0, 1));
         ra8 = 8'($urandom);
         rb8 = 8'($urandom);
         issue8(rs, ra8, rb8, ref8(rs, ra8, rb8));
         wait_done8("rand8");
      end

      repeat (4) @(negedge clk);
      check("q32_empty", 64'(q32.size()), 64'd0);
      check("q8_empty", 64'(q8.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
